ls_order_scheduler: RTL and testbench
=====================================

// Module: ls_order_scheduler
// PURPOSE
//  In-order load/store scheduler between the LS reservation station and the memory controller.
//  Allocates entries in program order at dispatch and fills each entry's address and store data
//  when the RS issues it; entries are matched by ROB id.
//  Issues one memory access at a time, from the head only. A load issues once its address is
//  known; a store also waits for ROB commit. Load results go onto the LS CDB.
// PARAMETERS
//  DEPTH  8  queue entries; must be a power of two
//  PTR_W  3  log2(DEPTH)
// PORTS
//  clk_in          in   1   system clock
//  rst_in          in   1   asynchronous reset, active-high
//  rdy_in          in   1   global ready; low freezes all state
//  clear_in        in   1   misprediction flush
//  alloc_valid     in   1   dispatch allocates the tail entry
//  alloc_rob_id    in   5   ROB id of the dispatched load/store
//  alloc_is_store  in   1   1 = store, 0 = load
//  alloc_funct3    in   3   RISC-V funct3 (size/sign)
//  alloc_full      out  1   queue full; dispatch must not allocate
//  rs_valid        in   1   RS delivers a computed address
//  rs_rob_id       in   5   ROB id of the delivering entry
//  rs_addr         in   32  effective address (v1+imm)
//  rs_st_value     in   32  store data; ignored for loads
//  commit_valid    in   1   ROB commits a store
//  commit_rob_id   in   5   ROB id of the committed store
//  mem_req_valid   out  1   memory request pending
//  mem_req_ready   in   1   memory controller accepts the request
//  mem_req_we      out  1   1 = write
//  mem_req_addr    out  32  byte address
//  mem_req_wdata   out  32  store data, LSB-aligned
//  mem_req_size    out  2   00 = byte, 01 = half, 10 = word
//  mem_resp_valid  in   1   read data valid / write done
//  mem_resp_rdata  in   32  raw read data, LSB-aligned
//  cdb_ls_ready    out  1   load result broadcast, one-cycle pulse
//  cdb_ls_rob_id   out  5   ROB id of the broadcast load
//  cdb_ls_value    out  32  extended load value
// BEHAVIOUR
//  Reset/clear values: all registered outputs are 0; head = tail = 0; count = 0; all valid bits 0.
//  Per-entry state: valid, is_store, funct3, rob_id, addr_rdy, addr, sdata, committed.
//  alloc_full = (count == DEPTH). Allocation while full is ignored.
//  Allocate and pop in the same cycle: count is unchanged.
//  rs_valid sets addr_rdy/addr/sdata on the valid entry with the matching rob_id. The entry was
//   allocated at least one cycle earlier. A non-matching rs_valid is ignored.
//  commit_valid sets committed on the matching store entry, even if its addr_rdy is still 0.
//  Head eligibility: valid && addr_rdy && (!is_store || committed).
//  FSM:
//   IDLE:   head eligible -> register the request, assert mem_req_valid next cycle, go REQ.
//   REQ:    hold mem_req_* stable until mem_req_ready is seen high -> WAIT.
//   WAIT:   on mem_resp_valid:
//             load  -> register cdb_ls_* (pulse next cycle), pop head, go IDLE;
//             store -> pop head, no broadcast, go IDLE.
//   DRAIN:  on mem_resp_valid -> IDLE; the response is discarded.
//  Minimum load latency: address ready -> CDB is 3 cycles plus memory latency.
//  Load extension by funct3: 000 LB sext8, 001 LH sext16, 010 LW, 100 LBU zext8, 101 LHU zext16.
//  Store size = funct3[1:0]; wdata is passed through unmasked.
//  clear_in behaviour by FSM state:
//   in IDLE: flush everything.
//   in REQ:  withdraw mem_req_valid.
//   in WAIT: a load in flight -> DRAIN; a committed store in flight -> stay WAIT, then pop.
//     A store in flight was committed, so it is never squashed.
//  clear_in and alloc_valid in the same cycle: clear wins.
//  rdy_in low: no state change. Memory inputs are not sampled.
//  rst_in asserted mid-transaction: immediate return to reset values, with no drain.
//  Pointers wrap modulo DEPTH.
// CONFIGURATION
//  LSQ_PERF_CNT_EN defined:
//   adds output perf_stall_cyc [31:0], counting cycles where the head is valid but not eligible;
//   the counter saturates at 0xFFFF_FFFF and is cleared only by rst_in.
//  LSQ_PERF_CNT_EN undefined: the port and counter are absent; behaviour is otherwise identical.
// STRUCTURE
//  Shared package: funct3 load/store localparams, mem size encodings, FSM state encoding,
//   ROB id width (5).
//  One sub-module, ls_load_extend: combinational funct3 + rdata -> 32-bit value.
// TESTING
//  1. LW: alloc rob 3, rs addr 0x100 -> mem_req{we=0, addr=0x100, size=10}; resp 0xDEADBEEF ->
//     cdb{rob 3, 0xDEADBEEF}.
//  2. LB/LBU: resp 0x80 -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
//  3. Store rob 5 at addr 0x200, value 0x12: with addr ready and no commit, no mem_req for 20 cycles.
//     After commit 5 -> mem_req{we=1, size=00, wdata=0x12}; no CDB pulse.
//  4. Ordering: alloc load rob 1 then load rob 2; rs fills rob 2 first -> no request until rob 1
//     fills; then issue order is rob 1, rob 2.
//  5. Full: 8 allocs -> alloc_full=1; a 9th alloc is ignored. A pop and an alloc in the same cycle
//     keep count at 8. Pointer wrap verified over 20 allocs.
//  6. Flush: clear during WAIT of a load -> DRAIN, resp discarded, no CDB pulse.
//     Clear during WAIT of a committed store -> write completes.

Source files
------------

// File: rtl/ls_order_scheduler_pkg.sv
// Shared types and constants for the in-order load/store scheduler.
// Covers funct3 load encodings, memory size codes, FSM states and the ROB id width.
package ls_order_scheduler_pkg;

    localparam int ROB_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } lsq_state_e;

    function automatic logic [1:0] f3_to_size(input logic [1:0] f3_lo);
        logic [1:0] w_sz;
        unique case (f3_lo)
            2'b00:   w_sz = SZ_BYTE;
            2'b01:   w_sz = SZ_HALF;
            2'b10:   w_sz = SZ_WORD;
            default: w_sz = f3_lo;
        endcase
        return w_sz;
    endfunction

endpackage

// File: rtl/ls_load_extend.sv
// Load result extension: picks the byte/half/word of raw read data and
// sign- or zero-extends it according to the RISC-V load funct3.
module ls_load_extend
    import ls_order_scheduler_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_value
);

    always_comb begin
        o_value = i_rdata;
        unique case (1'b1)
            (i_funct3 == F3_LB):  o_value = {{24{i_rdata[7]}}, i_rdata[7:0]};
            (i_funct3 == F3_LH):  o_value = {{16{i_rdata[15]}}, i_rdata[15:0]};
            (i_funct3 == F3_LBU): o_value = {24'h0, i_rdata[7:0]};
            (i_funct3 == F3_LHU): o_value = {16'h0, i_rdata[15:0]};
            default:              o_value = i_rdata;
        endcase
    end

endmodule

// File: rtl/ls_order_scheduler.sv
// In-order load/store queue issuing one memory access at a time from the head.
// Optional stall counter enabled by defining LSQ_PERF_CNT_EN.
module ls_order_scheduler
    import ls_order_scheduler_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
`ifdef LSQ_PERF_CNT_EN
    output logic [31:0]      perf_stall_cyc,
`endif
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear_in,
    input  logic             alloc_valid,
    input  logic [ROB_W-1:0] alloc_rob_id,
    input  logic             alloc_is_store,
    input  logic [2:0]       alloc_funct3,
    output logic             alloc_full,
    input  logic             rs_valid,
    input  logic [ROB_W-1:0] rs_rob_id,
    input  logic [31:0]      rs_addr,
    input  logic [31:0]      rs_st_value,
    input  logic             commit_valid,
    input  logic [ROB_W-1:0] commit_rob_id,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_req_we,
    output logic [31:0]      mem_req_addr,
    output logic [31:0]      mem_req_wdata,
    output logic [1:0]       mem_req_size,
    input  logic             mem_resp_valid,
    input  logic [31:0]      mem_resp_rdata,
    output logic             cdb_ls_ready,
    output logic [ROB_W-1:0] cdb_ls_rob_id,
    output logic [31:0]      cdb_ls_value
);

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_addr_rdy;
    logic [DEPTH-1:0] r_committed;
    logic [DEPTH-1:0] r_is_store;
    logic [2:0]       r_funct3 [DEPTH];
    logic [ROB_W-1:0] r_rob_id [DEPTH];
    logic [31:0]      r_addr   [DEPTH];
    logic [31:0]      r_sdata  [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    lsq_state_e       r_state;
    lsq_state_e       w_state_nxt;

    logic             r_req_valid;
    logic             r_req_we;
    logic [31:0]      r_req_addr;
    logic [31:0]      r_req_wdata;
    logic [1:0]       r_req_size;
    logic             r_cdb_ready;
    logic [ROB_W-1:0] r_cdb_rob_id;
    logic [31:0]      r_cdb_value;

    logic             w_full;
    logic             w_h_valid;
    logic             w_h_is_store;
    logic             w_h_store_cm;
    logic             w_head_elig;
    logic             w_alloc;
    logic             w_issue;
    logic             w_accept;
    logic             w_pop;
    logic             w_bcast;
    logic             w_keep_head;
    logic [DEPTH-1:0] w_rs_hit;
    logic [DEPTH-1:0] w_cm_hit;
    logic [31:0]      w_ext_value;

    assign w_full       = (r_count == FULL_CNT);
    assign w_h_valid    = r_valid[r_head];
    assign w_h_is_store = r_is_store[r_head];
    assign w_h_store_cm = w_h_valid && w_h_is_store && r_committed[r_head];
    assign w_head_elig  = w_h_valid && r_addr_rdy[r_head]
                          && (!w_h_is_store || r_committed[r_head]);
    // a pop frees the head slot, so a full queue may still take one entry
    assign w_alloc      = alloc_valid && !clear_in && (!w_full || w_pop);

    always_comb begin
        w_rs_hit = '0;
        w_cm_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rs_hit[i] = rs_valid && r_valid[i]
                          && (r_rob_id[i] == rs_rob_id);
            w_cm_hit[i] = commit_valid && r_valid[i] && r_is_store[i]
                          && (r_rob_id[i] == commit_rob_id);
        end
    end

    ls_load_extend u_ext (
        .i_funct3 (r_funct3[r_head]),
        .i_rdata  (mem_resp_rdata),
        .o_value  (w_ext_value)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_accept    = 1'b0;
        w_pop       = 1'b0;
        w_bcast     = 1'b0;
        w_keep_head = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!clear_in && w_head_elig) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (clear_in) begin
                    w_keep_head = w_h_store_cm;
                    w_state_nxt = ST_IDLE;
                end else if (mem_req_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_h_is_store) begin
                    // committed stores are never squashed
                    w_keep_head = clear_in;
                    if (mem_resp_valid) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (clear_in) begin
                    w_state_nxt = mem_resp_valid ? ST_IDLE : ST_DRAIN;
                end else if (mem_resp_valid) begin
                    w_pop       = 1'b1;
                    w_bcast     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (mem_resp_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rs_hit[i]) begin
                    r_addr[i]  <= rs_addr;
                    r_sdata[i] <= rs_st_value;
                end
            end
            if (w_alloc) begin
                r_is_store[r_tail] <= alloc_is_store;
                r_funct3[r_tail]   <= alloc_funct3;
                r_rob_id[r_tail]   <= alloc_rob_id;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_valid     <= '0;
            r_addr_rdy  <= '0;
            r_committed <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                r_valid <= '0;
                if (w_keep_head && !w_pop) begin
                    r_valid[r_head] <= 1'b1;
                    r_tail          <= r_head + 1'b1;
                    r_count         <= (PTR_W+1)'(1);
                end else begin
                    r_head  <= '0;
                    r_tail  <= '0;
                    r_count <= '0;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_rs_hit[i]) r_addr_rdy[i] <= 1'b1;
                    if (w_cm_hit[i]) r_committed[i] <= 1'b1;
                end
                if (w_pop) begin
                    r_valid[r_head] <= 1'b0;
                    r_head          <= r_head + 1'b1;
                end
                if (w_alloc) begin
                    r_valid[r_tail]     <= 1'b1;
                    r_addr_rdy[r_tail]  <= 1'b0;
                    r_committed[r_tail] <= 1'b0;
                    r_tail              <= r_tail + 1'b1;
                end
                r_count <= r_count + (PTR_W+1)'(w_alloc)
                                   - (PTR_W+1)'(w_pop);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_req_valid  <= 1'b0;
            r_req_we     <= 1'b0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
            r_req_size   <= '0;
            r_cdb_ready  <= 1'b0;
            r_cdb_rob_id <= '0;
            r_cdb_value  <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                r_req_valid  <= 1'b0;
                r_req_we     <= 1'b0;
                r_req_addr   <= '0;
                r_req_wdata  <= '0;
                r_req_size   <= '0;
                r_cdb_ready  <= 1'b0;
                r_cdb_rob_id <= '0;
                r_cdb_value  <= '0;
            end else begin
                r_cdb_ready <= w_bcast;
                if (w_bcast) begin
                    r_cdb_rob_id <= r_rob_id[r_head];
                    r_cdb_value  <= w_ext_value;
                end
                if (w_issue) begin
                    r_req_valid <= 1'b1;
                    r_req_we    <= w_h_is_store;
                    r_req_addr  <= r_addr[r_head];
                    r_req_wdata <= r_sdata[r_head];
                    r_req_size  <= f3_to_size(r_funct3[r_head][1:0]);
                end else if (w_accept) begin
                    r_req_valid <= 1'b0;
                end
            end
        end
    end

`ifdef LSQ_PERF_CNT_EN
    logic [31:0] r_stall_cyc;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_stall_cyc <= '0;
        end else if (rdy_in && w_h_valid && !w_head_elig
                     && (r_stall_cyc != 32'hFFFF_FFFF)) begin
            r_stall_cyc <= r_stall_cyc + 32'd1;
        end
    end

    assign perf_stall_cyc = r_stall_cyc;
`endif

    assign alloc_full    = w_full;
    assign mem_req_valid = r_req_valid;
    assign mem_req_we    = r_req_we;
    assign mem_req_addr  = r_req_addr;
    assign mem_req_wdata = r_req_wdata;
    assign mem_req_size  = r_req_size;
    assign cdb_ls_ready  = r_cdb_ready;
    assign cdb_ls_rob_id = r_cdb_rob_id;
    assign cdb_ls_value  = r_cdb_value;

endmodule

// File: tb/tb_ls_order_scheduler.sv
// Directed bench for ls_order_scheduler: vector table of single loads/stores
// followed by ordering, full/wrap, flush, freeze and reset sequences.
module tb_ls_order_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        alloc_valid;
    logic [4:0]  alloc_rob_id;
    logic        alloc_is_store;
    logic [2:0]  alloc_funct3;
    logic        alloc_full;
    logic        rs_valid;
    logic [4:0]  rs_rob_id;
    logic [31:0] rs_addr;
    logic [31:0] rs_st_value;
    logic        commit_valid;
    logic [4:0]  commit_rob_id;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [1:0]  mem_req_size;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        cdb_ls_ready;
    logic [4:0]  cdb_ls_rob_id;
    logic [31:0] cdb_ls_value;
`ifdef LSQ_PERF_CNT_EN
    logic [31:0] perf_stall_cyc;
`endif

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    ls_order_scheduler #(.DEPTH(8), .PTR_W(3)) dut (
`ifdef LSQ_PERF_CNT_EN
        .perf_stall_cyc (perf_stall_cyc),
`endif
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clear_in       (clear_in),
        .alloc_valid    (alloc_valid),
        .alloc_rob_id   (alloc_rob_id),
        .alloc_is_store (alloc_is_store),
        .alloc_funct3   (alloc_funct3),
        .alloc_full     (alloc_full),
        .rs_valid       (rs_valid),
        .rs_rob_id      (rs_rob_id),
        .rs_addr        (rs_addr),
        .rs_st_value    (rs_st_value),
        .commit_valid   (commit_valid),
        .commit_rob_id  (commit_rob_id),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_size   (mem_req_size),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .cdb_ls_ready   (cdb_ls_ready),
        .cdb_ls_rob_id  (cdb_ls_rob_id),
        .cdb_ls_value   (cdb_ls_value)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [4:0]  rob;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [1:0]  exp_size;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic alloc(input logic [4:0] rob, input logic st,
                         input logic [2:0] f3);
        alloc_valid    = 1'b1;
        alloc_rob_id   = rob;
        alloc_is_store = st;
        alloc_funct3   = f3;
        @(negedge clk_in);
        alloc_valid = 1'b0;
    endtask

    task automatic rs(input logic [4:0] rob, input logic [31:0] addr,
                      input logic [31:0] sd);
        rs_valid    = 1'b1;
        rs_rob_id   = rob;
        rs_addr     = addr;
        rs_st_value = sd;
        @(negedge clk_in);
        rs_valid = 1'b0;
    endtask

    task automatic commit(input logic [4:0] rob);
        commit_valid  = 1'b1;
        commit_rob_id = rob;
        @(negedge clk_in);
        commit_valid = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        int k = 0;
        while (!mem_req_valid && k < 50) begin
            @(negedge clk_in);
            k++;
        end
        chk({nm, "_req"}, 32'(mem_req_valid), 32'd1);
    endtask

    task automatic no_req(input int n, input string nm);
        logic seen = 1'b0;
        repeat (n) begin
            @(negedge clk_in);
            if (mem_req_valid) seen = 1'b1;
        end
        chk(nm, 32'(seen), 32'd0);
    endtask

    task automatic mem_txn(input string nm, input logic [31:0] rdata);
        mem_req_ready = 1'b1;
        @(negedge clk_in);
        mem_req_ready = 1'b0;
        chk({nm, "_req_drop"}, 32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        @(negedge clk_in);
        mem_resp_valid = 1'b0;
    endtask

    task automatic cdb_check(input string nm, input logic exp_cdb,
                             input logic [4:0] rob, input logic [31:0] val);
        chk({nm, "_cdb"}, 32'(cdb_ls_ready), 32'(exp_cdb));
        if (exp_cdb) begin
            chk({nm, "_cdb_rob"}, 32'(cdb_ls_rob_id), 32'(rob));
            chk({nm, "_cdb_val"}, cdb_ls_value, val);
        end
        @(negedge clk_in);
        chk({nm, "_cdb_pulse"}, 32'(cdb_ls_ready), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 3'b010, 5'd3,  32'h100, 32'h0,
                    32'hDEADBEEF, 2'b10, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 3'b000, 5'd4,  32'h104, 32'h0,
                    32'h00000080, 2'b00, 32'hFFFFFF80};
        vecs[2] = '{1'b0, 3'b100, 5'd6,  32'h105, 32'h0,
                    32'h00000080, 2'b00, 32'h00000080};
        vecs[3] = '{1'b0, 3'b001, 5'd7,  32'h106, 32'h0,
                    32'hABCD8001, 2'b01, 32'hFFFF8001};
        vecs[4] = '{1'b0, 3'b101, 5'd8,  32'h108, 32'h0,
                    32'hABCD8001, 2'b01, 32'h00008001};
        vecs[5] = '{1'b1, 3'b010, 5'd9,  32'h300, 32'hCAFEF00D,
                    32'h0, 2'b10, 32'h0};
        vecs[6] = '{1'b0, 3'b000, 5'd10, 32'h10A, 32'h0,
                    32'hABCDEF7F, 2'b00, 32'h0000007F};
        vecs[7] = '{1'b1, 3'b001, 5'd11, 32'h30E, 32'h0000BEEF,
                    32'h0, 2'b01, 32'h0};

        rst_in         = 1'b1;
        rdy_in         = 1'b1;
        clear_in       = 1'b0;
        alloc_valid    = 1'b0;
        alloc_rob_id   = '0;
        alloc_is_store = 1'b0;
        alloc_funct3   = '0;
        rs_valid       = 1'b0;
        rs_rob_id      = '0;
        rs_addr        = '0;
        rs_st_value    = '0;
        commit_valid   = 1'b0;
        commit_rob_id  = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);

        chk("rst_full",      32'(alloc_full),    32'd0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_cdb_ready", 32'(cdb_ls_ready),  32'd0);
        chk("rst_cdb_value", cdb_ls_value,       32'd0);

        for (int i = 0; i < 8; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            alloc(vecs[i].rob, vecs[i].st, vecs[i].f3);
            rs(vecs[i].rob, vecs[i].addr, vecs[i].sdata);
            if (vecs[i].st) commit(vecs[i].rob);
            wait_req(nm);
            chk({nm, "_we"},   32'(mem_req_we),   32'(vecs[i].st));
            chk({nm, "_addr"}, mem_req_addr,      vecs[i].addr);
            chk({nm, "_size"}, 32'(mem_req_size), 32'(vecs[i].exp_size));
            if (vecs[i].st) chk({nm, "_wdata"}, mem_req_wdata, vecs[i].sdata);
            mem_txn(nm, vecs[i].rdata);
            cdb_check(nm, !vecs[i].st, vecs[i].rob, vecs[i].exp_val);
        end

        alloc(5'd5, 1'b1, 3'b000);
        rs(5'd5, 32'h200, 32'h12);
        no_req(20, "st_nocommit");
        commit(5'd5);
        wait_req("st");
        chk("st_we",    32'(mem_req_we),   32'd1);
        chk("st_addr",  mem_req_addr,      32'h200);
        chk("st_size",  32'(mem_req_size), 32'd0);
        chk("st_wdata", mem_req_wdata,     32'h12);
        mem_txn("st", 32'h0);
        cdb_check("st", 1'b0, 5'd0, 32'h0);

        alloc(5'd1, 1'b0, 3'b010);
        alloc(5'd2, 1'b0, 3'b010);
        rs(5'd2, 32'h20, 32'h0);
        no_req(5, "ord_wait");
        rs(5'd1, 32'h10, 32'h0);
        wait_req("ord1");
        chk("ord1_addr", mem_req_addr, 32'h10);
        mem_txn("ord1", 32'h11);
        cdb_check("ord1", 1'b1, 5'd1, 32'h11);
        wait_req("ord2");
        chk("ord2_addr", mem_req_addr, 32'h20);
        mem_txn("ord2", 32'h22);
        cdb_check("ord2", 1'b1, 5'd2, 32'h22);

        for (int i = 0; i < 8; i++) alloc(5'(i), 1'b0, 3'b010);
        chk("full_set", 32'(alloc_full), 32'd1);
        alloc(5'd8, 1'b0, 3'b010);
        rs(5'd8, 32'hBAD0, 32'h0);
        for (int i = 0; i < 8; i++) rs(5'(i), 32'h1000 + 32'(4 * i), 32'h0);
        wait_req("full0");
        chk("full0_addr", mem_req_addr, 32'h1000);
        mem_req_ready = 1'b1;
        @(negedge clk_in);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h100;
        alloc_valid    = 1'b1;
        alloc_rob_id   = 5'd9;
        alloc_is_store = 1'b0;
        alloc_funct3   = 3'b010;
        @(negedge clk_in);
        mem_resp_valid = 1'b0;
        alloc_valid    = 1'b0;
        chk("full_popalloc", 32'(alloc_full), 32'd1);
        cdb_check("full0", 1'b1, 5'd0, 32'h100);
        rs(5'd9, 32'h2000, 32'h0);
        for (int j = 1; j < 9; j++) begin
            string nm;
            logic [4:0]  rob;
            logic [31:0] addr;
            nm   = $sformatf("full%0d", j);
            rob  = (j < 8) ? 5'(j) : 5'd9;
            addr = (j < 8) ? 32'h1000 + 32'(4 * j) : 32'h2000;
            wait_req(nm);
            chk({nm, "_addr"}, mem_req_addr, addr);
            mem_txn(nm, 32'h100 + 32'(j));
            cdb_check(nm, 1'b1, rob, 32'h100 + 32'(j));
        end
        chk("full_clear", 32'(alloc_full), 32'd0);
        no_req(10, "full_empty");

        alloc(5'd11, 1'b0, 3'b010);
        alloc(5'd13, 1'b0, 3'b010);
        rs(5'd11, 32'h40, 32'h0);
        rs(5'd13, 32'h44, 32'h0);
        wait_req("fl_ld");
        chk("fl_ld_addr", mem_req_addr, 32'h40);
        mem_req_ready = 1'b1;
        @(negedge clk_in);
        mem_req_ready = 1'b0;
        clear_in      = 1'b1;
        @(negedge clk_in);
        clear_in = 1'b0;
        no_req(3, "fl_ld_drain");
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h999;
        @(negedge clk_in);
        mem_resp_valid = 1'b0;
        chk("fl_ld_nocdb", 32'(cdb_ls_ready), 32'd0);
        alloc(5'd12, 1'b0, 3'b010);
        rs(5'd12, 32'h60, 32'h0);
        wait_req("fl_ld_next");
        chk("fl_ld_next_addr", mem_req_addr, 32'h60);
        mem_txn("fl_ld_next", 32'h66);
        cdb_check("fl_ld_next", 1'b1, 5'd12, 32'h66);

        alloc(5'd14, 1'b1, 3'b010);
        rs(5'd14, 32'h80, 32'h55);
        commit(5'd14);
        wait_req("fl_st");
        chk("fl_st_we", 32'(mem_req_we), 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clk_in);
        mem_req_ready = 1'b0;
        clear_in      = 1'b1;
        @(negedge clk_in);
        clear_in       = 1'b0;
        mem_resp_valid = 1'b1;
        @(negedge clk_in);
        mem_resp_valid = 1'b0;
        chk("fl_st_nocdb", 32'(cdb_ls_ready), 32'd0);
        no_req(5, "fl_st_popped");
        alloc(5'd15, 1'b0, 3'b010);
        rs(5'd15, 32'h90, 32'h0);
        wait_req("fl_st_next");
        chk("fl_st_next_addr", mem_req_addr, 32'h90);
        mem_txn("fl_st_next", 32'h15);
        cdb_check("fl_st_next", 1'b1, 5'd15, 32'h15);

        alloc(5'd16, 1'b0, 3'b010);
        rdy_in = 1'b0;
        rs(5'd16, 32'h70, 32'h0);
        rdy_in = 1'b1;
        no_req(5, "frz_rs_ignored");
        rs(5'd16, 32'h70, 32'h0);
        wait_req("frz");
        chk("frz_addr", mem_req_addr, 32'h70);
        mem_txn("frz", 32'h16);
        cdb_check("frz", 1'b1, 5'd16, 32'h16);

        alloc_valid    = 1'b1;
        alloc_rob_id   = 5'd17;
        alloc_is_store = 1'b0;
        alloc_funct3   = 3'b010;
        clear_in       = 1'b1;
        @(negedge clk_in);
        alloc_valid = 1'b0;
        clear_in    = 1'b0;
        rs(5'd17, 32'h74, 32'h0);
        no_req(5, "clr_alloc");

        alloc(5'd18, 1'b0, 3'b010);
        rs(5'd18, 32'h78, 32'h0);
        wait_req("rst_mid");
        rst_in = 1'b1;
        #1;
        chk("rst_mid_req",  32'(mem_req_valid), 32'd0);
        chk("rst_mid_addr", mem_req_addr,       32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        no_req(5, "rst_mid_empty");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
